line_plot_controller: RTL and testbench



---
 rtl/line_plot_controller_pkg.sv | 18 +
 rtl/line_plot_controller_bresenham_step.sv | 48 ++++
 rtl/line_plot_controller.sv | 185 ++++++++++++++++++
 tb/tb_line_plot_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_plot_controller_pkg.sv
// Shared definitions for the line plot controller and the VGA-level tops.
// Holds the controller state encoding and the 160x120 screen geometry.
package line_plot_controller_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int COORD_X_WIDTH = 8;
  localparam int COORD_Y_WIDTH = 7;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LINE_INIT,
    LINE_DRAW,
    FINISH
  } state_t;

endpackage

// File: rtl/line_plot_controller_bresenham_step.sv
// One Bresenham iteration: computes the next (x, y, err) from the current
// point, error term and the per-line constants dx (>= 0), dy (<= 0) and the
// step directions.
// Ports:
//   x, y, err         current point and error term
//   dx, dy            |x1-x0| and -|y1-y0|
//   sx_neg, sy_neg    1 when the axis steps by -1, 0 when it steps by +1
//   next_x, next_y, next_err  updated point and error term
module line_plot_controller_bresenham_step #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7,
  parameter int E_WIDTH = 10
) (
  input  logic                       sx_neg,
  input  logic                       sy_neg,
  input  logic        [X_WIDTH-1:0]  x,
  input  logic        [Y_WIDTH-1:0]  y,
  input  logic signed [E_WIDTH-1:0]  err,
  input  logic signed [E_WIDTH-1:0]  dx,
  input  logic signed [E_WIDTH-1:0]  dy,
  output logic        [X_WIDTH-1:0]  next_x,
  output logic        [Y_WIDTH-1:0]  next_y,
  output logic signed [E_WIDTH-1:0]  next_err
);

  // One extra bit so 2*err cannot overflow.
  logic signed [E_WIDTH:0] e2;
  logic                    step_x;
  logic                    step_y;

  always_comb begin
    e2       = (E_WIDTH+1)'(err) <<< 1;
    step_x   = (e2 >= (E_WIDTH+1)'(dy));
    step_y   = (e2 <= (E_WIDTH+1)'(dx));
    next_err = err;
    next_x   = x;
    next_y   = y;
    if (step_x) begin
      next_err = next_err + dy;
      next_x   = sx_neg ? (x - X_WIDTH'(1)) : (x + X_WIDTH'(1));
    end
    if (step_y) begin
      next_err = next_err + dx;
      next_y   = sy_neg ? (y - Y_WIDTH'(1)) : (y + Y_WIDTH'(1));
    end
  end

endmodule

// File: rtl/line_plot_controller.sv
// Drives the vga_adapter pixel port (x, y, colour, plot) from two commands:
// a full-screen clear sweep and a Bresenham line draw, one pixel per clock.
// Ports:
//   clock, resetn        system clock, synchronous active-low reset
//   start, clear         command requests, honoured only while ready=1
//   x0, y0, x1, y1       line endpoints (saturated to X_MAX/Y_MAX on latch)
//   colour_in            line colour
//   ready                idle and accepting commands
//   done                 one-cycle pulse after the last pixel of a command
//   x, y, colour, plot   registered pixel write port to the adapter
module line_plot_controller
  import line_plot_controller_pkg::*;
#(
  parameter int         X_WIDTH        = COORD_X_WIDTH,
  parameter int         Y_WIDTH        = COORD_Y_WIDTH,
  parameter int         X_MAX          = SCREEN_WIDTH - 1,
  parameter int         Y_MAX          = SCREEN_HEIGHT - 1,
  parameter logic [2:0] CLEAR_COLOUR   = 3'b000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               clear,
  input  logic [X_WIDTH-1:0] x0,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [2:0]         colour_in,
  output logic               ready,
  output logic               done,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic [2:0]         colour,
  output logic               plot
);

  localparam int E_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
  localparam logic [X_WIDTH-1:0] X_LIM = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_LIM = Y_WIDTH'(Y_MAX);

  state_t                    state;
  logic                      boot;       // first cycle after reset release
  logic        [X_WIDTH-1:0] clr_x;
  logic        [Y_WIDTH-1:0] clr_y;
  logic        [X_WIDTH-1:0] cur_x;
  logic        [Y_WIDTH-1:0] cur_y;
  logic        [X_WIDTH-1:0] end_x;
  logic        [Y_WIDTH-1:0] end_y;
  logic        [2:0]         line_colour;
  logic signed [E_WIDTH-1:0] dx;
  logic signed [E_WIDTH-1:0] dy;
  logic signed [E_WIDTH-1:0] err;
  logic                      sx_neg;
  logic                      sy_neg;

  logic signed [E_WIDTH-1:0] init_dx;
  logic signed [E_WIDTH-1:0] init_dy;
  logic        [X_WIDTH-1:0] step_x;
  logic        [Y_WIDTH-1:0] step_y;
  logic signed [E_WIDTH-1:0] step_err;

  // Line setup from the latched endpoints; coordinates are zero-extended
  // into the signed error width before subtracting.
  always_comb begin
    init_dx = (end_x >= cur_x) ? (E_WIDTH'(end_x) - E_WIDTH'(cur_x))
                               : (E_WIDTH'(cur_x) - E_WIDTH'(end_x));
    init_dy = (end_y >= cur_y) ? (E_WIDTH'(cur_y) - E_WIDTH'(end_y))
                               : (E_WIDTH'(end_y) - E_WIDTH'(cur_y));
  end

  line_plot_controller_bresenham_step #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .E_WIDTH (E_WIDTH)
  ) u_step (
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .x        (cur_x),
    .y        (cur_y),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .next_x   (step_x),
    .next_y   (step_y),
    .next_err (step_err)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      boot        <= 1'b1;
      ready       <= 1'b0;
      done        <= 1'b0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      clr_x       <= '0;
      clr_y       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      end_x       <= '0;
      end_y       <= '0;
      line_colour <= '0;
      dx          <= '0;
      dy          <= '0;
      err         <= '0;
      sx_neg      <= 1'b0;
      sy_neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (boot) begin
            // Commands are not accepted until ready has been seen high.
            boot <= 1'b0;
            if (CLEAR_ON_RESET) begin
              state <= CLEAR;
              clr_x <= '0;
              clr_y <= '0;
            end else begin
              ready <= 1'b1;
            end
          end else if (clear) begin
            ready <= 1'b0;
            state <= CLEAR;
            clr_x <= '0;
            clr_y <= '0;
          end else if (start) begin
            ready       <= 1'b0;
            state       <= LINE_INIT;
            cur_x       <= (x0 > X_LIM) ? X_LIM : x0;
            cur_y       <= (y0 > Y_LIM) ? Y_LIM : y0;
            end_x       <= (x1 > X_LIM) ? X_LIM : x1;
            end_y       <= (y1 > Y_LIM) ? Y_LIM : y1;
            line_colour <= colour_in;
          end
        end
        CLEAR: begin
          plot   <= 1'b1;
          x      <= clr_x;
          y      <= clr_y;
          colour <= CLEAR_COLOUR;
          if (clr_x == X_LIM) begin
            clr_x <= '0;
            if (clr_y == Y_LIM) state <= FINISH;
            else clr_y <= clr_y + Y_WIDTH'(1);
          end else begin
            clr_x <= clr_x + X_WIDTH'(1);
          end
        end
        LINE_INIT: begin
          dx     <= init_dx;
          dy     <= init_dy;
          err    <= init_dx + init_dy;
          sx_neg <= !(cur_x < end_x);
          sy_neg <= !(cur_y < end_y);
          state  <= LINE_DRAW;
        end
        LINE_DRAW: begin
          plot   <= 1'b1;
          x      <= cur_x;
          y      <= cur_y;
          colour <= line_colour;
          if (cur_x == end_x && cur_y == end_y) begin
            state <= FINISH;
          end else begin
            cur_x <= step_x;
            cur_y <= step_y;
            err   <= step_err;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_plot_controller.sv
module tb_line_plot_controller;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic       clear;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] colour_in;
  logic       ready;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  always #5 clock = ~clock;

  line_plot_controller dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .clear     (clear),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .colour_in (colour_in),
    .ready     (ready),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  int tests  = 0;
  int failed = 0;
  int qx[$];
  int qy[$];
  int qc[$];
  int first_cyc;
  int done_cyc;
  int timed_out;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Record every plotted pixel until done; optionally pulse start at cycle pulse_at.
  task automatic collect(input int budget, input int pulse_at);
    qx.delete();
    qy.delete();
    qc.delete();
    first_cyc = -1;
    done_cyc  = -1;
    timed_out = 1;
    for (int c = 1; c <= budget; c++) begin
      if (c == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (plot) begin
        if (first_cyc < 0) first_cyc = c;
        qx.push_back(int'(x));
        qy.push_back(int'(y));
        qc.push_back(int'(colour));
      end
      if (done) begin
        done_cyc  = c;
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic launch_line(input int ax0, input int ay0, input int ax1,
                             input int ay1, input int col);
    x0 = 8'(ax0);
    y0 = 7'(ay0);
    x1 = 8'(ax1);
    y1 = 7'(ay1);
    colour_in = 3'(col);
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(300, 0);
  endtask

  task automatic check_sweep(input string tag, input int exp_first);
    int pos_err = 0;
    int col_err = 0;
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_count"}, qx.size(), 19200);
    for (int i = 0; i < qx.size(); i++) begin
      if (qx[i] != i % 160 || qy[i] != i / 160) pos_err++;
      if (qc[i] != 0) col_err++;
    end
    check({tag, "_order_errors"}, pos_err, 0);
    check({tag, "_colour_errors"}, col_err, 0);
    if (qx.size() == 19200) begin
      check({tag, "_first_xy"}, qx[0] * 1000 + qy[0], 0);
      check({tag, "_second_xy"}, qx[1] * 1000 + qy[1], 1000);
      check({tag, "_161st_xy"}, qx[160] * 1000 + qy[160], 1);
      check({tag, "_last_xy"}, qx[19199] * 1000 + qy[19199], 159119);
    end
    check({tag, "_first_cycle"}, first_cyc, exp_first);
    check({tag, "_done_cycle"}, done_cyc, exp_first + 19200);
    check({tag, "_ready"}, int'(ready), 1);
    check({tag, "_plot_at_done"}, int'(plot), 0);
  endtask

  int bx[11];
  int errs;
  int extra_plots;
  int extra_dones;
  int seen;

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    colour_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_plot", int'(plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_xy", int'(x) * 1000 + int'(y), 0);
    check("rst_colour", int'(colour), 0);

    // Automatic clear after reset release
    resetn = 1'b1;
    collect(25000, 0);
    check_sweep("boot_clear", 2);

    // Horizontal line (10,10)->(20,10), colour 4
    launch_line(10, 10, 20, 10, 4);
    check("h_timeout", timed_out, 0);
    check("h_count", qx.size(), 11);
    errs = 0;
    for (int i = 0; i < qx.size(); i++)
      if (qx[i] != 10 + i || qy[i] != 10 || qc[i] != 4) errs++;
    check("h_pixel_errors", errs, 0);
    check("h_first_cycle", first_cyc, 2);
    check("h_done_cycle", done_cyc, 13);
    check("h_ready", int'(ready), 1);

    // Reverse steep line (7,15)->(5,5)
    bx = '{7, 7, 7, 6, 6, 6, 6, 6, 5, 5, 5};
    launch_line(7, 15, 5, 5, 2);
    check("steep_count", qx.size(), 11);
    errs = 0;
    for (int i = 0; i < qx.size() && i < 11; i++)
      if (qx[i] != bx[i] || qy[i] != 15 - i || qc[i] != 2) errs++;
    check("steep_pixel_errors", errs, 0);
    check("steep_done_cycle", done_cyc, 13);

    // Single point at a screen corner
    launch_line(0, 119, 0, 119, 5);
    check("pt_count", qx.size(), 1);
    if (qx.size() == 1) check("pt_xy", qx[0] * 1000 + qy[0], 119);
    check("pt_first_cycle", first_cyc, 2);
    check("pt_done_cycle", done_cyc, 3);

    // Out-of-range endpoints saturate to (159,119)
    launch_line(200, 127, 200, 127, 1);
    check("sat_count", qx.size(), 1);
    if (qx.size() == 1) check("sat_xy", qx[0] * 1000 + qy[0], 159119);
    check("sat_done_cycle", done_cyc, 3);

    // clear and start together, then start pulsed mid-sweep
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd5; y1 = 7'd0; colour_in = 3'd7;
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("cs_ready_low", int'(ready), 0);
    collect(25000, 100);
    check_sweep("cs_clear", 1);
    extra_plots = 0;
    extra_dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (plot) extra_plots++;
      if (done) extra_dones++;
    end
    check("cs_extra_plots", extra_plots, 0);
    check("cs_extra_dones", extra_dones, 0);

    // Reset during a diagonal at pixel 20
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd50; y1 = 7'd50; colour_in = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 20; i++) begin
      tick();
      if (plot) seen++;
    end
    check("diag_pixels_seen", seen, 20);
    check("diag_pixel20_xy", int'(x) * 1000 + int'(y), 19019);
    resetn = 1'b0;
    tick();
    check("diag_rst_plot", int'(plot), 0);
    check("diag_rst_xy", int'(x) * 1000 + int'(y), 0);
    check("diag_rst_done", int'(done), 0);
    check("diag_rst_ready", int'(ready), 0);
    resetn = 1'b1;
    collect(25000, 0);
    check_sweep("diag_reclear", 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
